// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/decode/execute/writeback control for the 8-bit RISC core
// Define OVF_TRAP_EN to stop in TRAP on ADD/SUB overflow instead of writing back.
module alu_sequencer #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   output logic [PC_WIDTH-1:0] o_imem_addr,
   output logic                o_imem_req,
   input  logic                i_imem_ack,
   input  logic [7:0]          i_imem_data,
   output logic [2:0]          o_alu_ctrl,
   input  logic                i_alu_ovf,
   output logic [1:0]          o_rf_ra1,
   output logic [1:0]          o_rf_ra2,
   output logic [1:0]          o_rf_wa,
   output logic                o_rf_we,
   output logic                o_halted,
   output logic                o_ovf_flag,
   output logic                o_trap
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NOP  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b111;

`ifdef OVF_TRAP_EN
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT, S_TRAP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
   } state_t;
`endif

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [7:0]          r_ir;
   logic                r_imem_req;
   logic [2:0]          r_alu_ctrl;
   logic [1:0]          r_rf_ra1;
   logic [1:0]          r_rf_ra2;
   logic [1:0]          r_rf_wa;
   logic                r_rf_we;
   logic                r_halted;
   logic                r_ovf_flag;

   logic [2:0] w_op;
   logic       w_add_ovf;

   assign w_op      = r_ir[7:5];
   // Only ADD/SUB report signed overflow; the flag is meaningless for the logic/shift ops.
   assign w_add_ovf = ((w_op == OP_ADD) || (w_op == OP_SUB)) && i_alu_ovf;

`ifdef OVF_TRAP_EN
   logic r_trap;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_ir       <= 8'h00;
         r_imem_req <= 1'b0;
         r_alu_ctrl <= 3'b000;
         r_rf_ra1   <= 2'b00;
         r_rf_ra2   <= 2'b00;
         r_rf_wa    <= 2'b00;
         r_rf_we    <= 1'b0;
         r_halted   <= 1'b0;
         r_ovf_flag <= 1'b0;
`ifdef OVF_TRAP_EN
         r_trap     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (i_imem_ack) begin
                  r_ir       <= i_imem_data;
                  r_imem_req <= 1'b0;
                  r_state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_rf_ra1 <= r_ir[4:3];
               r_rf_wa  <= r_ir[4:3];
               r_rf_ra2 <= r_ir[2:1];
               case (w_op)
                  OP_HALT: begin
                     r_alu_ctrl <= 3'b000;
                     r_halted   <= 1'b1;
                     r_state    <= S_HALT;
                  end
                  OP_NOP: begin
                     r_alu_ctrl <= 3'b000;
                     r_state    <= S_WRITEBACK;
                  end
                  default: begin
                     r_alu_ctrl <= w_op;
                     r_state    <= S_EXECUTE;
                  end
               endcase
            end
            S_EXECUTE: begin
               if (w_add_ovf) begin
                  r_ovf_flag <= 1'b1;
               end
`ifdef OVF_TRAP_EN
               if (w_add_ovf) begin
                  r_trap   <= 1'b1;
                  r_halted <= 1'b1;
                  r_state  <= S_TRAP;
               end else begin
                  r_rf_we <= 1'b1;
                  r_state <= S_WRITEBACK;
               end
`else
               r_rf_we <= 1'b1;
               r_state <= S_WRITEBACK;
`endif
            end
            S_WRITEBACK: begin
               r_rf_we    <= 1'b0;
               r_pc       <= r_pc + PC_WIDTH'(1);
               r_imem_req <= 1'b1;
               r_state    <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
`ifdef OVF_TRAP_EN
            S_TRAP: begin
               r_state <= S_TRAP;
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_imem_addr = r_pc;
   assign o_imem_req  = r_imem_req;
   assign o_alu_ctrl  = r_alu_ctrl;
   assign o_rf_ra1    = r_rf_ra1;
   assign o_rf_ra2    = r_rf_ra2;
   assign o_rf_wa     = r_rf_wa;
   assign o_rf_we     = r_rf_we;
   assign o_halted    = r_halted;
   assign o_ovf_flag  = r_ovf_flag;
`ifdef OVF_TRAP_EN
   assign o_trap      = r_trap;
`else
   assign o_trap      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, ack, alu_ovf;
   logic [7:0] data;
   logic [7:0] addr;
   logic       req, we, halted, ovf_flag, trap;
   logic [2:0] ctrl;
   logic [1:0] ra1, ra2, wa;

   logic       start_w, ack_w;
   logic [7:0] data_w;
   logic [7:0] addr_w;
   logic       req_w, we_w, halted_w, ovf_w, trap_w;
   logic [2:0] ctrl_w;
   logic [1:0] ra1_w, ra2_w, wa_w;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_pc;

   always #5 clk = ~clk;

   alu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_imem_addr(addr), .o_imem_req(req), .i_imem_ack(ack), .i_imem_data(data),
      .o_alu_ctrl(ctrl), .i_alu_ovf(alu_ovf),
      .o_rf_ra1(ra1), .o_rf_ra2(ra2), .o_rf_wa(wa), .o_rf_we(we),
      .o_halted(halted), .o_ovf_flag(ovf_flag), .o_trap(trap)
   );

   alu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'hFE)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_start(start_w),
      .o_imem_addr(addr_w), .o_imem_req(req_w), .i_imem_ack(ack_w), .i_imem_data(data_w),
      .o_alu_ctrl(ctrl_w), .i_alu_ovf(1'b0),
      .o_rf_ra1(ra1_w), .o_rf_ra2(ra2_w), .o_rf_wa(wa_w), .o_rf_we(we_w),
      .o_halted(halted_w), .o_ovf_flag(ovf_w), .o_trap(trap_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && req !== 1'b1; i++) cycle();
      check({tag, "_req"}, req, 1);
   endtask

   task automatic run_instr(input string tag, input logic [7:0] instr, input logic ovf_in,
                            input logic [2:0] exp_ctrl);
      wait_req(tag);
      check({tag, "_addr"}, addr, exp_pc);
      ack = 1'b1; data = instr;
      cycle();
      ack = 1'b0;
      cycle();
      check({tag, "_ctrl"}, ctrl, exp_ctrl);
      if (instr[7:5] == 3'b101) begin
         check({tag, "_nop_we"}, we, 0);
         cycle();
      end else begin
         alu_ovf = ovf_in;
         cycle();
         alu_ovf = 1'b0;
         check({tag, "_we"}, we, 1);
         check({tag, "_wa"}, wa, instr[4:3]);
         cycle();
         check({tag, "_we_drop"}, we, 0);
      end
      exp_pc = exp_pc + 8'd1;
      check({tag, "_next_req"}, req, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ack = 1'b0; data = 8'h00; alu_ovf = 1'b0;
      start_w = 1'b0; ack_w = 1'b0; data_w = 8'h00;
      exp_pc = 8'h00;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (10) cycle();
      check("rst_req", req, 0);
      check("rst_addr", addr, 8'h00);
      check("rst_outs", {ctrl, ra1, ra2, wa, we, halted, ovf_flag, trap}, 0);

      start = 1'b1;
      cycle();
      start = 1'b0;
      check("start_req", req, 1);

      ack = 1'b1; data = 8'h0A;
      cycle();
      ack = 1'b0;
      check("add_req_drop", req, 0);
      cycle();
      check("add_ctrl", ctrl, 3'b000);
      check("add_ra1", ra1, 2'b01);
      check("add_ra2", ra2, 2'b01);
      check("add_we_early", we, 0);
      cycle();
      check("add_we", we, 1);
      check("add_wa", wa, 2'b01);
      cycle();
      check("add_we_one", we, 0);
      check("add_pc", addr, 8'h01);
      check("add_next_req", req, 1);
      exp_pc = 8'h01;

      repeat (5) begin
         cycle();
         check("ws_req", req, 1);
         check("ws_addr", addr, 8'h01);
      end
      ack = 1'b1; data = 8'hDC;
      cycle();
      ack = 1'b0;
      cycle();
      check("sll_ctrl", ctrl, 3'b110);
      check("sll_wa", wa, 2'b11);
      check("sll_ra2", ra2, 2'b10);
      cycle();
      check("sll_we", we, 1);
      cycle();
      exp_pc = 8'h02;

      run_instr("sub", 8'h20, 1'b0, 3'b001);
      run_instr("nor", 8'h60, 1'b0, 3'b011);
      run_instr("nand", 8'h80, 1'b0, 3'b100);
      run_instr("nop", 8'hA0, 1'b0, 3'b000);
      check("nop_pc", addr, 8'h06);

      run_instr("srl_ovf", 8'h40, 1'b1, 3'b010);
      check("srl_ovf_flag", ovf_flag, 0);

`ifdef OVF_TRAP_EN
      wait_req("trap");
      ack = 1'b1; data = 8'h08;
      cycle();
      ack = 1'b0;
      cycle();
      alu_ovf = 1'b1;
      cycle();
      alu_ovf = 1'b0;
      check("trap_trap", trap, 1);
      check("trap_halted", halted, 1);
      check("trap_flag", ovf_flag, 1);
      repeat (3) begin
         cycle();
         check("trap_we", we, 0);
         check("trap_req", req, 0);
      end
      check("trap_pc", addr, exp_pc);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_pc = 8'h00;
      start = 1'b1;
      cycle();
      start = 1'b0;
`else
      run_instr("add_ovf", 8'h08, 1'b1, 3'b000);
      check("add_ovf_flag", ovf_flag, 1);
      check("add_ovf_trap", trap, 0);
      run_instr("sub_after", 8'h2A, 1'b0, 3'b001);
      check("ovf_sticky", ovf_flag, 1);
`endif

      wait_req("halt");
      ack = 1'b1; data = 8'hE0;
      cycle();
      ack = 1'b0;
      cycle();
      check("halt_halted", halted, 1);
      check("halt_req", req, 0);
      check("halt_pc", addr, exp_pc);
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (5) cycle();
      check("halt_hold_halted", halted, 1);
      check("halt_hold_req", req, 0);
      check("halt_hold_we", we, 0);
      check("halt_hold_pc", addr, exp_pc);

      #2 rst = 1'b1;
      #1;
      check("async_halted", halted, 0);
      check("async_addr", addr, 8'h00);
      check("async_ovf", ovf_flag, 0);
      cycle();
      rst = 1'b0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      ack = 1'b1; data = 8'hDC;
      cycle();
      ack = 1'b0;
      cycle();
      check("mid_ctrl_pre", ctrl, 3'b110);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ctrl", ctrl, 0);
      check("mid_rst_addrs", {ra1, ra2, wa}, 0);
      check("mid_rst_req", req, 0);
      cycle();
      rst = 1'b0;
      cycle();

      check("wrap_reset_pc", addr_w, 8'hFE);
      start_w = 1'b1;
      cycle();
      start_w = 1'b0;
      check("wrap_req", req_w, 1);
      ack_w = 1'b1; data_w = 8'hA0;
      cycle();
      ack_w = 1'b0;
      cycle();
      cycle();
      check("wrap_ff", addr_w, 8'hFF);
      check("wrap_req2", req_w, 1);
      ack_w = 1'b1; data_w = 8'hA0;
      cycle();
      ack_w = 1'b0;
      cycle();
      cycle();
      check("wrap_00", addr_w, 8'h00);
      check("wrap_we", we_w, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit RISC core; the producer of the ALU's 3-bit operation select.
- Fetches 8-bit instructions over a req/ack handshake and decodes them.
- Drives the ALU operation code and register-file addresses/write enable, and consumes the ALU overflow flag.
- Sits between instruction memory and the datapath (register file + ALU).

Parameters:
PC_WIDTH, 8, width of program counter / instruction address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE and begins fetching at current PC
imem_addr  output  PC_WIDTH  instruction address (= PC)
imem_req  output  1  fetch request
imem_ack  input  1  instruction valid on imem_data this cycle
imem_data  input  8  instruction word
alu_ctrl  output  3  ALU op select: 000 add, 001 sub, 010 srl, 011 nor, 100 nand, 110 sll
alu_ovf  input  1  ALU overflow (combinational from ALU)
rf_ra1  output  2  register file read address 1 (rs1)
rf_ra2  output  2  register file read address 2 (rs2)
rf_wa  output  2  register file write address (rd)
rf_we  output  1  register file write enable
halted  output  1  core halted
ovf_flag  output  1  sticky overflow status
trap  output  1  overflow trap taken (constant 0 without OVF_TRAP_EN)

Behaviour:
- Instruction format: [7:5] opcode, [4:3] rd (also rs1), [2:1] rs2, [0] reserved/ignored.
- Opcodes 000/001/010/011/100/110 are ALU ops, passed unchanged to alu_ctrl. 101 = NOP. 111 = HALT.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT (+ TRAP with macro).
- Reset (async, any state, mid-instruction included): state=IDLE, PC=RESET_PC, IR=0x00. All outputs 0: imem_req, rf_we, alu_ctrl=000, rf_ra1/ra2/wa=00, halted, ovf_flag, trap.
- IDLE: wait for start=1 -> FETCH next cycle. start is ignored in every other state.
- FETCH: imem_req=1, held until imem_ack=1. On the ack cycle, latch IR=imem_data, drop imem_req next cycle, go to DECODE. imem_ack outside FETCH is ignored. Wait states are unbounded.
- DECODE: register alu_ctrl=IR[7:5] (000 for NOP/HALT), rf_ra1=rf_wa=IR[4:3], rf_ra2=IR[2:1].
  - HALT -> HALT state.
  - NOP -> WRITEBACK with no write.
  - Otherwise -> EXECUTE.
- EXECUTE: ALU settles; sample alu_ovf at end of cycle. For opcode 000/001 with alu_ovf=1, set ovf_flag. alu_ovf is ignored for other opcodes. -> WRITEBACK.
- WRITEBACK:
  - rf_we=1 for exactly this one cycle, for ALU opcodes only; 0 for NOP.
  - PC <= PC+1, modulo 2^PC_WIDTH (0xFF -> 0x00 wraps silently).
  - -> FETCH.
- HALT: halted=1, imem_req=0, rf_we=0. Exit only by reset. PC holds the address of the HALT instruction.
- alu_ctrl and the rf addresses hold their last values outside DECODE, until the next DECODE.
- ovf_flag is sticky; cleared only by reset.
- Throughput: 4 cycles per ALU instruction with zero-wait ack (FETCH, DECODE, EXECUTE, WRITEBACK). 3 cycles for NOP.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined: ADD/SUB overflow in EXECUTE sets ovf_flag and goes to TRAP instead of WRITEBACK.
  - Writeback suppressed (rf_we stays 0); PC not incremented.
  - trap=1 and halted=1 until reset.
- Undefined: no TRAP state. Overflow only sets ovf_flag; writeback and PC increment proceed normally; trap tied 0.

Test Plan:
- Reset/start: assert rst mid-stream, release, hold start=0 10 cycles -> imem_req=0, imem_addr=0x00, all outputs 0. Pulse start -> imem_req=1 next cycle.
- ADD, zero-wait: imem_data=0x0A (op 000, rd=01, rs2=01), ack same cycle as req -> alu_ctrl=000, rf_ra1=01, rf_ra2=01. rf_we=1 with rf_wa=01 exactly 3 cycles after the ack cycle. PC 0x00->0x01. Next imem_req 4 cycles after the first.
- Fetch wait states: hold imem_ack=0 for 5 cycles -> imem_req stays 1, imem_addr stable. Then ack with 0xDC (op 110, rd=11, rs2=10) -> alu_ctrl=110, rf_wa=11.
- Opcode sweep: issue 0x20, 0x60, 0x80 then NOP 0xA0 -> alu_ctrl sequence 001, 011, 100. NOP gives no rf_we pulse and still increments PC. Then HALT 0xE0 -> halted=1, imem_req=0 forever, PC = HALT address. Start pulses are ignored.
- Overflow: ADD with alu_ovf forced 1 in EXECUTE -> ovf_flag=1 and stays 1 across later instructions. Same for SRL with alu_ovf=1 -> ovf_flag unaffected.
  - With OVF_TRAP_EN: trap=1, halted=1, no rf_we, PC unchanged.
- PC wrap: RESET_PC=0xFE, two NOPs -> imem_addr 0xFE, 0xFF, then 0x00.
